// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl: round-robin write arbiter and write-side pointer/flag logic for an async FIFO
module fifo_wr_arb_ctrl #(
  parameter int ADDR_SIZE    = 6,
  parameter int DATA_SIZE    = 8,
  parameter int AFULL_THRESH = 4
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 req0,
  input  logic [DATA_SIZE-1:0] data0,
  output logic                 gnt0,
  input  logic                 req1,
  input  logic [DATA_SIZE-1:0] data1,
  output logic                 gnt1,
  input  logic [ADDR_SIZE:0]   syn_rptr,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [DATA_SIZE-1:0] wdata,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel
);
  localparam logic [ADDR_SIZE:0] AF_LVL = (ADDR_SIZE+1)'((2**ADDR_SIZE) - AFULL_THRESH);
  logic [ADDR_SIZE:0] r_wbin, r_wptr, r_wlevel;
  logic [ADDR_SIZE:0] w_wbin_next, w_wgray_next, w_rbin, w_wlevel_next;
  logic               r_wfull, r_walmost_full, r_last_gnt;
  // Grants are suppressed while reset is held so no write slips in mid-reset
  assign gnt0 = ~w_rst & req0 & ~r_wfull & (~req1 | r_last_gnt);
  assign gnt1 = ~w_rst & req1 & ~r_wfull & (~req0 | ~r_last_gnt);
  assign wen   = gnt0 | gnt1;
  assign waddr = r_wbin[ADDR_SIZE-1:0];
  assign wdata = gnt1 ? data1 : data0;
  assign w_wbin_next   = r_wbin + {{ADDR_SIZE{1'b0}}, wen};
  assign w_wgray_next  = w_wbin_next ^ (w_wbin_next >> 1);
  assign w_wlevel_next = w_wbin_next - w_rbin;
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) w_rbin[i] = ^(syn_rptr >> i);
  end
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wlevel       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_last_gnt     <= 1'b1;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      r_wlevel       <= w_wlevel_next;
      r_wfull        <= w_wgray_next == {~syn_rptr[ADDR_SIZE:ADDR_SIZE-1], syn_rptr[ADDR_SIZE-2:0]};
      r_walmost_full <= w_wlevel_next >= AF_LVL;
      r_last_gnt     <= wen ? gnt1 : r_last_gnt;
    end
  end
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
endmodule

// File: doc/fifo_wr_arb_ctrl.md
Name: fifo_wr_arb_ctrl

Overview:
- Write-domain controller for the asynchronous FIFO.
- Arbitrates two write requesters onto the single FIFO RAM write port using round-robin.
- Owns the write pointer in binary and Gray form.
- Derives full, almost-full and fill level from the read pointer after it has passed through the 2-flop read-to-write synchronizer.
- Sits between the producers, the dual-port RAM write side, and the synchronizer output.

Parameters:
- ADDR_SIZE, 6, RAM address width; depth = 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits; legal values ≥ 2.
- DATA_SIZE, 8, write data width.
- AFULL_THRESH, 4, walmost_full asserts when free entries ≤ AFULL_THRESH.

Ports:
- w_clk  in  1  write-domain clock.
- w_rst  in  1  reset, asynchronous assert, active-high.
- req0  in  1  requester 0 write request; held until granted.
- data0  in  DATA_SIZE  requester 0 write data.
- gnt0  out  1  requester 0 grant; write occurs on this edge.
- req1  in  1  requester 1 write request.
- data1  in  DATA_SIZE  requester 1 write data.
- gnt1  out  1  requester 1 grant.
- syn_rptr  in  ADDR_SIZE+1  Gray read pointer, already synchronized to w_clk.
- wen  out  1  RAM write enable.
- waddr  out  ADDR_SIZE  RAM write address.
- wdata  out  DATA_SIZE  RAM write data.
- wptr  out  ADDR_SIZE+1  Gray write pointer, registered; feeds the write-to-read synchronizer.
- wfull  out  1  FIFO full, registered.
- walmost_full  out  1  free entries ≤ AFULL_THRESH, registered.
- wlevel  out  ADDR_SIZE+1  occupied entries as seen from write side, registered.

Behaviour:
- Reset values, all asynchronous on w_rst high:
  - wbin = 0, wptr = 0
  - wfull = 0, walmost_full = 0, wlevel = 0
  - last_gnt = 1, so requester 0 wins first contention.
- Grant is combinational in the same cycle:
  - gnt0 = req0 & ~wfull & (~req1 | last_gnt==1)
  - gnt1 = req1 & ~wfull & (~req0 | last_gnt==0)
  - At most one grant per cycle.
- Write port:
  - wen = gnt0 | gnt1
  - waddr = wbin[ADDR_SIZE-1:0]
  - wdata = data of the granted requester, else data0.
  - Zero latency: RAM captures on the same w_clk edge the grant is high.
- Round-robin: on each edge with a grant, last_gnt <= index of the granted requester. With no grant, last_gnt holds.
- Pointer update on each edge:
  - wbin_next = wbin + wen, wrapping modulo 2^(ADDR_SIZE+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - wbin <= wbin_next; wptr <= wgray_next.
- Full:
  - wfull <= (wgray_next == {~syn_rptr[ADDR_SIZE:ADDR_SIZE-1], syn_rptr[ADDR_SIZE-2:0]}).
  - Asserts on the edge that writes the last free entry, so no grant is issued in the following cycle.
- Level:
  - rbin = Gray-to-binary of syn_rptr.
  - wlevel <= (wbin_next − rbin) modulo 2^(ADDR_SIZE+1); range 0..2^ADDR_SIZE.
- Almost-full: walmost_full <= (wlevel_next ≥ 2^ADDR_SIZE − AFULL_THRESH).
- Flags are pessimistic. syn_rptr lags the real read pointer by 2+ cycles, so wfull deasserts on the first edge after syn_rptr advances. The block never declares not-full falsely.
- While full, requests stay pending with no grant, wen = 0 and the pointer holds. Requests are never dropped.
- Simultaneous read advance and write on the same edge: level and full use the new syn_rptr and wbin_next together. If a slot is freed on the edge that would fill, wfull stays 0.
- Reset mid-operation:
  - Pointers and flags clear immediately; pending requests receive no grant while w_rst is high.
  - The read domain must be reset concurrently; this is a system requirement.

Test Plan:
- Reset, then single request: req0 = 1 with data0 = 0xA5 → gnt0 = 1 the same cycle, wen = 1, waddr = 0, wdata = 0xA5; next cycle wptr = 1, wlevel = 1.
- Contention: req0 = req1 = 1 held for 4 cycles → grant sequence 0, 1, 0, 1; waddr 0, 1, 2, 3; never both grants high.
- Fill: syn_rptr = 0, req0 held for 70 cycles → 64 grants; walmost_full rises after write 60 (wlevel = 60); wfull rises after write 64 (wptr = Gray 64 = 0x60); no grant or wen afterwards.
- Drain release: from full, set syn_rptr = Gray(1) = 0x01 → next edge wfull = 0 and wlevel = 63; a pending req1 is granted the following cycle with waddr = 0.
- Wrap: with syn_rptr tracking wbin − 2, perform 130 writes → wbin wraps 127→0, waddr wraps 63→0, wlevel stays 2, wfull never asserts.
- Asynchronous reset mid-burst: assert w_rst between edges during writes → wptr, wlevel, wfull clear immediately without a clock edge; after release, req1-only traffic grants starting at waddr = 0.
